// File: rtl/pierce_tt_pkg.sv
// pierce_tt_pkg: shared types and constants for the Pierce-arrow truth-table
// checker.
//   state_t               - checker FSM states (IDLE, SETTLE, SAMPLE, DONE)
//   MAX_N_INPUTS          - widest gate under test the checker supports
//   DEFAULT_SETTLE_CYCLES - default operand hold time before sampling
package pierce_tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int MAX_N_INPUTS          = 4;
    localparam int DEFAULT_SETTLE_CYCLES = 1;

endpackage

// File: rtl/pierce_settle_timer.sv
// pierce_settle_timer: loadable down-counter that measures the operand
// settle window.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - restart the window (counter <= SETTLE_CYCLES-1)
//   expired    - high when the window has elapsed (counter == 0)
// After a load, expired is low for SETTLE_CYCLES-1 cycles and then high,
// so a state that leaves on expired lasts exactly SETTLE_CYCLES cycles.
module pierce_settle_timer
    import pierce_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pierce_tt_checker.sv
// pierce_tt_checker: walks every operand vector of a combinational gate
// under test, samples its output after a settle window and compares it
// with a captured expected truth table.
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - one-cycle request to run a check (ignored unless IDLE)
//   exp_tt        - expected truth table, bit k = output for vector k
//   dut_in        - registered operand vector driven to the gate
//   dut_y         - gate output
//   busy          - high while vectors are being applied/sampled
//   done          - one-cycle pulse when a check completes
//   pass          - result of the last completed check
//   fail_idx      - first mismatching vector index (0 if none)
//   mismatch_mask - bit k set if vector k mismatched
//   state_dbg     - current FSM state (pierce_tt_pkg::state_t encoding)
// Build option: define PIERCE_TT_STOP_ON_FAIL_EN to end the run at the first
// mismatch instead of always checking all vectors.
module pierce_tt_checker
    import pierce_tt_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    localparam int V            = 1 << N_INPUTS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [V-1:0]        exp_tt,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS-1:0] fail_idx,
    output logic [V-1:0]        mismatch_mask,
    output logic [1:0]          state_dbg
);

    if (N_INPUTS < 1 || N_INPUTS > MAX_N_INPUTS) begin : g_bad_n_inputs
        $error("pierce_tt_checker: N_INPUTS must be in 1..%0d", MAX_N_INPUTS);
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("pierce_tt_checker: SETTLE_CYCLES must be >= 1");
    end

    localparam logic [N_INPUTS-1:0] LAST_IDX = N_INPUTS'(V - 1);
    localparam logic [V-1:0]        ONE_HOT0 = V'(1);

    state_t              state, state_nxt;
    logic [V-1:0]        tt_q;
    logic [N_INPUTS-1:0] idx;
    logic                first_fail_seen;

    logic                timer_load;
    logic                timer_expired;
    logic                accept;
    logic                advance;
    logic                sample_bad;
    logic                last_vec;
    logic [V-1:0]        mask_nxt;

    pierce_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .expired(timer_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        last_vec   = (idx == LAST_IDX);
        sample_bad = (state == SAMPLE) && (dut_y != tt_q[idx]);
        // Mask including this cycle's sample, so pass can see a mismatch
        // found on the final vector.
        mask_nxt   = mismatch_mask | (sample_bad ? (ONE_HOT0 << idx) : '0);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_expired) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
`ifdef PIERCE_TT_STOP_ON_FAIL_EN
                if (last_vec || sample_bad) begin
`else
                if (last_vec) begin
`endif
                    state_nxt = DONE;
                end else begin
                    advance    = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = SETTLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand index, captured table and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q            <= '0;
            idx             <= '0;
            first_fail_seen <= 1'b0;
            pass            <= 1'b0;
            fail_idx        <= '0;
            mismatch_mask   <= '0;
        end else begin
            if (accept) begin
                tt_q            <= exp_tt;
                idx             <= '0;
                first_fail_seen <= 1'b0;
                fail_idx        <= '0;
                mismatch_mask   <= '0;
            end
            if (state == SAMPLE) begin
                mismatch_mask <= mask_nxt;
                if (sample_bad && !first_fail_seen) begin
                    first_fail_seen <= 1'b1;
                    fail_idx        <= idx;
                end
                if (advance) begin
                    idx <= idx + 1'b1;
                end
                if (state_nxt == DONE) begin
                    pass <= (mask_nxt == '0);
                end
            end
        end
    end

    // idx is a register, so the operand bus is glitch-free
    assign dut_in    = idx;
    assign busy      = (state == SETTLE) || (state == SAMPLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pierce_tt_checker.sv
// tb_pierce_tt_checker: directed, table-driven bench for pierce_tt_checker.
// Instance a: N_INPUTS=2, SETTLE_CYCLES=1 around a NOR-only implication
// (optionally tied to 0). Instance b: N_INPUTS=1, SETTLE_CYCLES=3 around a
// NOR-built inverter.
module tb_pierce_tt_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic nor2(input logic x, input logic y);
        return ~(x | y);
    endfunction

    // ---------------- instance a ----------------
    logic       start_a;
    logic [3:0] exp_tt_a;
    logic [1:0] dut_in_a;
    logic       dut_y_a;
    logic       busy_a, done_a, pass_a;
    logic [1:0] fail_idx_a;
    logic [3:0] mask_a;
    logic [1:0] state_a;
    logic       tie0;
    logic       na, t_or;

    // a -> b == NOR(NOR(NOR(a,a), b), NOR(NOR(a,a), b)); a = bit1, b = bit0
    assign na      = nor2(dut_in_a[1], dut_in_a[1]);
    assign t_or    = nor2(na, dut_in_a[0]);
    assign dut_y_a = tie0 ? 1'b0 : nor2(t_or, t_or);

    pierce_tt_checker #(.N_INPUTS(2), .SETTLE_CYCLES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .exp_tt(exp_tt_a),
        .dut_in(dut_in_a), .dut_y(dut_y_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .fail_idx(fail_idx_a), .mismatch_mask(mask_a),
        .state_dbg(state_a)
    );

    // ---------------- instance b ----------------
    logic       start_b;
    logic [1:0] exp_tt_b;
    logic [0:0] dut_in_b;
    logic       dut_y_b;
    logic       busy_b, done_b, pass_b;
    logic [0:0] fail_idx_b;
    logic [1:0] mask_b;
    logic [1:0] state_b;

    assign dut_y_b = nor2(dut_in_b[0], dut_in_b[0]);

    pierce_tt_checker #(.N_INPUTS(1), .SETTLE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .exp_tt(exp_tt_b),
        .dut_in(dut_in_b), .dut_y(dut_y_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .fail_idx(fail_idx_b), .mismatch_mask(mask_b),
        .state_dbg(state_b)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic prev_pass;

    // ---------------- driver tasks ----------------
    // Runs one check on instance a. Edge 0 is the edge that samples start.
    task automatic run_a(input string tag, input logic [3:0] tt, input bit repulse,
                         output int done_edge, output int n_done, output int max_in,
                         output bit seq_ok, output logic busy_in_done);
        @(negedge clk);
        exp_tt_a = tt;
        start_a  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a  = 1'b0;
        exp_tt_a = ~tt;  // must not affect the running check
        done_edge = -1; n_done = 0; max_in = 0; seq_ok = 1'b1; busy_in_done = 1'b1;
        if (dut_in_a !== 2'd0 || busy_a !== 1'b1) seq_ok = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            start_a = (repulse && (k == 3 || k == 8)) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (k == 1) check({tag, "_pass_held"}, 32'(pass_a), 32'(prev_pass));
            if (done_a === 1'b1) begin
                n_done++;
                if (done_edge < 0) begin
                    done_edge    = k;
                    busy_in_done = busy_a;
                end
            end else if (done_edge < 0) begin
                if (busy_a !== 1'b1 || dut_in_a !== 2'(k / 2)) seq_ok = 1'b0;
            end
            if (int'(dut_in_a) > max_in) max_in = int'(dut_in_a);
        end
        start_a = 1'b0;
    endtask

    task automatic run_b(input logic [1:0] tt, output int done_edge, output bit seq_ok);
        @(negedge clk);
        exp_tt_b = tt;
        start_b  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b  = 1'b0;
        done_edge = -1; seq_ok = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a === 1'b1 && 1'b0) seq_ok = 1'b0;
            if (done_b === 1'b1) begin
                if (done_edge < 0) done_edge = k;
            end else if (done_edge < 0) begin
                if (busy_b !== 1'b1 || dut_in_b !== 1'(k / 4)) seq_ok = 1'b0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] tt;
        bit         tie0;
        bit         pass;
        logic [3:0] mask;
        logic [1:0] fidx;
        int         done_edge;
        int         max_in;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   de, nd, mx;
        bit   ok;
        logic bid;

`ifdef PIERCE_TT_STOP_ON_FAIL_EN
        vecs[0] = '{4'b1011, 1'b0, 1'b1, 4'b0000, 2'd0, 8, 3};
        vecs[1] = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 6, 2};
        vecs[2] = '{4'b1011, 1'b1, 1'b0, 4'b0001, 2'd0, 2, 0};
        vecs[3] = '{4'b1001, 1'b0, 1'b0, 4'b0010, 2'd1, 4, 1};
        vecs[4] = '{4'b0011, 1'b0, 1'b0, 4'b1000, 2'd3, 8, 3};
`else
        vecs[0] = '{4'b1011, 1'b0, 1'b1, 4'b0000, 2'd0, 8, 3};
        vecs[1] = '{4'b1111, 1'b0, 1'b0, 4'b0100, 2'd2, 8, 3};
        vecs[2] = '{4'b1011, 1'b1, 1'b0, 4'b1011, 2'd0, 8, 3};
        vecs[3] = '{4'b1001, 1'b0, 1'b0, 4'b0010, 2'd1, 8, 3};
        vecs[4] = '{4'b0011, 1'b0, 1'b0, 4'b1000, 2'd3, 8, 3};
`endif

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        exp_tt_a = 4'b0; exp_tt_b = 2'b0; tie0 = 1'b0;
        prev_pass = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_outputs", {dut_in_a, busy_a, done_a, pass_a, fail_idx_a, mask_a}, 32'd0);
        check("rst_a_state", 32'(state_a), 32'd0);
        check("rst_b_outputs", {dut_in_b, busy_b, done_b, pass_b, fail_idx_b, mask_b}, 32'd0);
        rst_n = 1'b1;

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            tie0 = vecs[i].tie0;
            run_a($sformatf("v%0d", i), vecs[i].tt, 1'b0, de, nd, mx, ok, bid);
            check($sformatf("v%0d_done_edge", i), 32'(de), 32'(vecs[i].done_edge));
            check($sformatf("v%0d_done_count", i), 32'(nd), 32'd1);
            check($sformatf("v%0d_pass", i), 32'(pass_a), 32'(vecs[i].pass));
            check($sformatf("v%0d_mask", i), 32'(mask_a), 32'(vecs[i].mask));
            check($sformatf("v%0d_fail_idx", i), 32'(fail_idx_a), 32'(vecs[i].fidx));
            check($sformatf("v%0d_dut_in_seq", i), 32'(ok), 32'd1);
            check($sformatf("v%0d_max_dut_in", i), 32'(mx), 32'(vecs[i].max_in));
            check($sformatf("v%0d_busy_in_done", i), 32'(bid), 32'd0);
            prev_pass = vecs[i].pass;
        end
        tie0 = 1'b0;

        // start re-pulsed at edges 3 and 8: ignored, single done at edge 8
        run_a("repulse", 4'b1011, 1'b1, de, nd, mx, ok, bid);
        check("repulse_done_edge", 32'(de), 32'd8);
        check("repulse_done_count", 32'(nd), 32'd1);
        check("repulse_busy_in_done", 32'(bid), 32'd0);
        check("repulse_idle_after", 32'(state_a), 32'd0);
        check("repulse_pass", 32'(pass_a), 32'd1);
        prev_pass = 1'b1;

        // Reset asserted mid-run, between edges, after edge 4
        @(negedge clk);
        exp_tt_a = 4'b1111;
        start_a  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {dut_in_a, busy_a, done_a, pass_a, fail_idx_a, mask_a}, 32'd0);
        check("midrst_state", 32'(state_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_pass = 1'b0;
        run_a("after_rst", 4'b1011, 1'b0, de, nd, mx, ok, bid);
        check("after_rst_done_edge", 32'(de), 32'd8);
        check("after_rst_pass", 32'(pass_a), 32'd1);
        check("after_rst_dut_in_seq", 32'(ok), 32'd1);

        // Instance b: N_INPUTS=1, SETTLE_CYCLES=3, NOR inverter
        run_b(2'b01, de, ok);
        check("b_done_edge", 32'(de), 32'd8);
        check("b_pass", 32'(pass_b), 32'd1);
        check("b_mask", 32'(mask_b), 32'd0);
        check("b_dut_in_seq", 32'(ok), 32'd1);
        run_b(2'b11, de, ok);
        check("b_fail_done_edge", 32'(de), 32'd8);
        check("b_fail_pass", 32'(pass_b), 32'd0);
        check("b_fail_mask", 32'(mask_b), 32'b10);
        check("b_fail_idx", 32'(fail_idx_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
